// File: rtl/pcs_block_sync.sv
// -----------------------------------------------------------------------------
// pcs_block_sync
//   Receive-side block aligner. Reassembles BLOCK_W-bit blocks from the
//   DATA_W-bit SERDES word stream with a variable-fill gearbox. While
//   searching, it slips one bit per invalid sync header until a run of
//   LOCK_CNT valid headers declares lock. While locked, it monitors headers
//   in windows of WIN_CNT blocks and drops lock after BAD_LIM bad headers
//   in one window.
//
// Ports
//   rx_par_clk     in   1        sole clock
//   nreset         in   1        synchronous active-low reset
//   rx_locked_i    in   1        CDR locked; input words are ignored when low
//   rx_par_data_i  in   DATA_W   parallel word, bit 0 received first
//   block_o        out  BLOCK_W  reassembled block, header in [HEAD_W-1:0]
//   block_v_o      out  1        block_o valid this cycle
//   block_lock_o   out  1        block lock achieved
//   slip_o         out  1        a 1-bit slip was applied (debug pulse)
// -----------------------------------------------------------------------------
module pcs_block_sync #(
    parameter int DATA_W   = 64,
    parameter int HEAD_W   = 2,
    parameter int BLOCK_W  = HEAD_W + DATA_W,
    parameter int LOCK_CNT = 64,
    parameter int WIN_CNT  = 64,
    parameter int BAD_LIM  = 16
) (
    input  logic               rx_par_clk,
    input  logic               nreset,
    input  logic               rx_locked_i,
    input  logic [DATA_W-1:0]  rx_par_data_i,
    output logic [BLOCK_W-1:0] block_o,
    output logic               block_v_o,
    output logic               block_lock_o,
    output logic               slip_o
);

    localparam int BUF_W  = DATA_W + BLOCK_W - 1;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int SH_W   = $clog2(LOCK_CNT) + 1;
    localparam int WIN_W  = $clog2(WIN_CNT) + 1;
    localparam int BAD_W  = $clog2(BAD_LIM) + 1;

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t             r_state;
    logic [BUF_W-1:0]   r_buf;
    logic [FILL_W-1:0]  r_fill;
    logic               r_drop;
    logic [SH_W-1:0]    r_sh_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [BAD_W-1:0]   r_bad_cnt;

    logic [DATA_W-1:0]  w_word;
    logic [FILL_W-1:0]  w_avail;
    logic [BUF_W-1:0]   w_cat;
    logic               w_emit;
    logic [BLOCK_W-1:0] w_cand;
    logic               w_hdr_ok;
    logic               w_slip;
    logic [FILL_W-1:0]  w_consume;
    logic               w_under;
    logic [FILL_W-1:0]  w_fill_next;
    logic [BUF_W-1:0]   w_rest;
    logic [SH_W-1:0]    w_sh_next;
    logic [WIN_W-1:0]   w_win_next;
    logic [BAD_W-1:0]   w_bad_next;

    // A slip taken when the buffer holds exactly one block has nothing left
    // to discard, so r_drop carries it over and bit 0 of the next word is
    // dropped instead.
    assign w_word  = r_drop ? (rx_par_data_i >> 1) : rx_par_data_i;
    assign w_avail = r_fill + (r_drop ? FILL_W'(DATA_W - 1) : FILL_W'(DATA_W));

    // Bits above r_fill are always zero, so the new word is simply OR-ed in.
    assign w_cat    = r_buf | (BUF_W'(w_word) << r_fill);
    assign w_emit   = (w_avail >= FILL_W'(BLOCK_W));
    assign w_cand   = w_cat[BLOCK_W-1:0];
    assign w_hdr_ok = (w_cand[HEAD_W-1:0] == HEAD_W'(2'b01)) ||
                      (w_cand[HEAD_W-1:0] == HEAD_W'(2'b10));

    assign w_sh_next  = r_sh_cnt + SH_W'(1);
    assign w_win_next = r_win_cnt + WIN_W'(1);
    assign w_bad_next = r_bad_cnt + BAD_W'(!w_hdr_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_slip = 1'b0;
        if (w_emit) begin
            case (r_state)
                ST_SEARCH: w_slip = !w_hdr_ok;
                ST_LOCKED: w_slip = (w_bad_next == BAD_W'(BAD_LIM));
                default:   w_slip = 1'b0;
            endcase
        end
    end

    assign w_consume   = (w_emit ? FILL_W'(BLOCK_W) : '0) + FILL_W'(w_slip);
    assign w_under     = w_slip && (w_avail == FILL_W'(BLOCK_W));
    assign w_fill_next = w_under ? '0 : (w_avail - w_consume);
    assign w_rest      = w_cat >> w_consume;

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge rx_par_clk) begin
        if (!nreset) begin
            // NOTE: the gearbox buffer is reset, not just its fill count, because
            // the OR-merge above relies on the unused upper bits being zero.
            r_buf        <= '0;
            r_fill       <= '0;
            r_drop       <= 1'b0;
            r_state      <= ST_SEARCH;
            r_sh_cnt     <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            block_o      <= '0;
            block_v_o    <= 1'b0;
            block_lock_o <= 1'b0;
            slip_o       <= 1'b0;
        end else if (!rx_locked_i) begin
            // Loss of CDR lock: discard everything and search from an empty buffer.
            r_buf        <= '0;
            r_fill       <= '0;
            r_drop       <= 1'b0;
            r_state      <= ST_SEARCH;
            r_sh_cnt     <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            block_v_o    <= 1'b0;
            block_lock_o <= 1'b0;
            slip_o       <= 1'b0;
        end else begin
            r_buf     <= w_rest;
            r_fill    <= w_fill_next;
            r_drop    <= w_under;
            block_v_o <= w_emit;
            slip_o    <= w_slip;
            if (w_emit) begin
                block_o <= w_cand;
                case (r_state)
                    ST_SEARCH: begin
                        if (!w_hdr_ok) begin
                            r_sh_cnt <= '0;
                        end else if (w_sh_next == SH_W'(LOCK_CNT)) begin
                            r_state      <= ST_LOCKED;
                            block_lock_o <= 1'b1;
                            r_sh_cnt     <= '0;
                            r_win_cnt    <= '0;
                            r_bad_cnt    <= '0;
                        end else begin
                            r_sh_cnt <= w_sh_next;
                        end
                    end
                    ST_LOCKED: begin
                        // Loss of lock wins over the end-of-window clear.
                        if (w_bad_next == BAD_W'(BAD_LIM)) begin
                            r_state      <= ST_SEARCH;
                            block_lock_o <= 1'b0;
                            r_sh_cnt     <= '0;
                            r_win_cnt    <= '0;
                            r_bad_cnt    <= '0;
                        end else if (w_win_next == WIN_W'(WIN_CNT)) begin
                            r_win_cnt <= '0;
                            r_bad_cnt <= '0;
                        end else begin
                            r_win_cnt <= w_win_next;
                            r_bad_cnt <= w_bad_next;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule
